// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
//   Instruction-fetch stage that sits upstream of the control unit. It holds
//   the PC and fetches from instruction memory over a req/valid handshake. It
//   presents the fetched instruction and its opcode to decode, and it computes
//   the next PC from the control unit's PcSrc/PCWre when the instruction retires.
//
//   Parameters
//     RESET_PC   PC after reset (word-aligned)
//     MAX_WAIT   FETCH cycles without imem_valid before fetch_err
//     CNT_W      wait-counter width, 2**CNT_W > MAX_WAIT
//
//   Ports
//     CLK         in   rising-edge clock
//     Reset       in   synchronous, active-low reset
//     PCWre       in   0 = halt when the current instruction retires
//     PcSrc[1:0]  in   00 seq, 01 branch, 10 jump, 11 treated as seq
//     imm_ext     in   sign/zero-extended immediate (word offset for branch)
//     jaddr       in   26-bit jump target field
//     ins_ready   in   datapath retires the issued instruction this cycle
//     imem_valid  in   memory response valid
//     imem_rdata  in   memory response data
//     imem_req    out  fetch request
//     imem_addr   out  fetch address (always equals pc)
//     ins         out  issued instruction register
//     op          out  ins[31:26]
//     ins_valid   out  ins is live for decode/execute
//     pc          out  current PC
//     pc_plus4    out  pc + 4
//     halted      out  halt reached (leaves only through reset)
//     fetch_err   out  fetch timeout, sticky until reset
module pc_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned MAX_WAIT = 15,
   parameter int unsigned CNT_W    = 4
) (
   input  logic        CLK,
   input  logic        Reset,
   input  logic        PCWre,
   input  logic [1:0]  PcSrc,
   input  logic [31:0] imm_ext,
   input  logic [25:0] jaddr,
   input  logic        ins_ready,
   input  logic        imem_valid,
   input  logic [31:0] imem_rdata,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   output logic [31:0] ins,
   output logic [5:0]  op,
   output logic        ins_valid,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        halted,
   output logic        fetch_err
);

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      ISSUE = 2'd1,
      HALT  = 2'd2,
      ERR   = 2'd3
   } stateT;

   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT - 1);

   stateT            state;
   logic [CNT_W-1:0] waitCnt;
   logic [31:0]      nextPc;

   assign pc_plus4  = pc + 32'd4;
   assign imem_addr = pc;
   assign op        = ins[31:26];

   // Branch offset is a word offset, hence the shift; the jump keeps the
   // upper nibble of the sequential PC.
   always_comb begin
      nextPc = pc_plus4;
      unique case (PcSrc)
         2'b01:   nextPc = pc_plus4 + (imm_ext << 2);
         2'b10:   nextPc = {pc_plus4[31:28], jaddr, 2'b00};
         default: nextPc = pc_plus4;
      endcase
   end

   // Status outputs are flops updated on the same transitions as state, so
   // each one is a clean registered decode of the current state.
   always_ff @(posedge CLK) begin
      if (!Reset) begin
         state     <= FETCH;
         pc        <= RESET_PC;
         ins       <= '0;
         waitCnt   <= '0;
         imem_req  <= 1'b1;
         ins_valid <= 1'b0;
         halted    <= 1'b0;
         fetch_err <= 1'b0;
      end else begin
         unique case (state)
            FETCH: begin
               if (imem_valid) begin
                  ins       <= imem_rdata;
                  waitCnt   <= '0;
                  state     <= ISSUE;
                  imem_req  <= 1'b0;
                  ins_valid <= 1'b1;
               end else if (waitCnt == WAIT_LAST) begin
                  state     <= ERR;
                  imem_req  <= 1'b0;
                  fetch_err <= 1'b1;
               end else begin
                  waitCnt <= waitCnt + CNT_W'(1);
               end
            end
            ISSUE: begin
               if (ins_ready) begin
                  ins_valid <= 1'b0;
                  if (PCWre) begin
                     pc       <= nextPc;
                     state    <= FETCH;
                     imem_req <= 1'b1;
                  end else begin
                     state  <= HALT;
                     halted <= 1'b1;
                  end
               end
            end
            HALT: state <= HALT;
            ERR:  state <= ERR;
            default: state <= ERR;
         endcase
      end
   end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit
//   Scoreboard bench for pc_fetch_unit. The stimulus process plays the memory
//   and the datapath on a fixed timeline, advances a reference PC with plain
//   arithmetic, and queues the expected fetch addresses and issued
//   instructions. A separate monitor samples the DUT after every rising edge
//   and checks it against those queues and the expected status flags.
module tb_pc_fetch_unit;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int unsigned MAX_WAIT = 15;

   logic        CLK;
   logic        Reset;
   logic        PCWre;
   logic [1:0]  PcSrc;
   logic [31:0] imm_ext;
   logic [25:0] jaddr;
   logic        ins_ready;
   logic        imem_valid;
   logic [31:0] imem_rdata;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] ins;
   logic [5:0]  op;
   logic        ins_valid;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        halted;
   logic        fetch_err;

   pc_fetch_unit #(
      .RESET_PC (RESET_PC),
      .MAX_WAIT (MAX_WAIT),
      .CNT_W    (4)
   ) dut (
      .CLK        (CLK),
      .Reset      (Reset),
      .PCWre      (PCWre),
      .PcSrc      (PcSrc),
      .imm_ext    (imm_ext),
      .jaddr      (jaddr),
      .ins_ready  (ins_ready),
      .imem_valid (imem_valid),
      .imem_rdata (imem_rdata),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .ins        (ins),
      .op         (op),
      .ins_valid  (ins_valid),
      .pc         (pc),
      .pc_plus4   (pc_plus4),
      .halted     (halted),
      .fetch_err  (fetch_err)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   typedef struct {
      logic [31:0] pc;
      logic [31:0] ins;
   } issueT;

   issueT       expIssue[$];
   logic [31:0] expFetch[$];
   logic [31:0] mpc;
   logic [31:0] holdPc;
   logic        expReq, expValid, expHalt, expErr, expRst, checkEn;
   int          tests  = 0;
   int          errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chkBit(input string name, input logic act, input logic exp);
      tests++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   // Reference next-PC: sequential, word-offset branch, or 256MB-region jump.
   function automatic logic [31:0] refNext(input logic [31:0] p, input logic [1:0] src,
                                           input logic [31:0] imm, input logic [25:0] ja);
      logic [31:0] seq;
      seq = p + 32'd4;
      case (src)
         2'b01:   return seq + imm * 32'd4;
         2'b10:   return (seq & 32'hF000_0000) | ({6'd0, ja} * 32'd4);
         default: return seq;
      endcase
   endfunction

   // Control inputs that must not matter outside the retire edge.
   task automatic junk();
      PcSrc   = 2'($urandom);
      PCWre   = 1'($urandom);
      imm_ext = $urandom;
      jaddr   = 26'($urandom);
   endtask

   task automatic drive(input logic v, input logic [31:0] d, input logic r);
      Reset      = 1'b1;
      expRst     = 1'b0;
      imem_valid = v;
      imem_rdata = d;
      ins_ready  = r;
   endtask

   // Two reset edges with a stray memory response that must be ignored.
   task automatic doReset();
      @(negedge CLK);
      Reset      = 1'b0;
      imem_valid = 1'b1;
      imem_rdata = $urandom;
      ins_ready  = 1'($urandom);
      junk();
      expIssue.delete();
      expFetch.delete();
      expFetch.push_back(RESET_PC);
      mpc      = RESET_PC;
      expReq   = 1'b1;
      expValid = 1'b0;
      expHalt  = 1'b0;
      expErr   = 1'b0;
      expRst   = 1'b1;
      checkEn  = 1'b1;
      @(negedge CLK);
      imem_rdata = $urandom;
   endtask

   task automatic idle(input int unsigned n, input bit noisy);
      for (int unsigned k = 0; k < n; k++) begin
         @(negedge CLK);
         drive(noisy ? 1'($urandom) : 1'b0, $urandom, 1'($urandom));
         junk();
      end
   endtask

   // One instruction: lat empty FETCH cycles, response, stall cycles in ISSUE
   // (optionally with stray responses), then retire with the given controls.
   task automatic runInstr(input int unsigned lat, input int unsigned stall, input bit stray,
                           input logic [1:0] src, input logic wre,
                           input logic [31:0] imm, input logic [25:0] ja);
      logic [31:0] d;
      d = $urandom;
      for (int unsigned k = 0; k < lat; k++) begin
         @(negedge CLK);
         drive(1'b0, $urandom, 1'($urandom));
         junk();
         if (k == MAX_WAIT - 1) begin
            expReq = 1'b0;
            expErr = 1'b1;
            expFetch.delete();
            return;
         end
      end
      @(negedge CLK);
      drive(1'b1, d, 1'($urandom));
      junk();
      expIssue.push_back('{pc: mpc, ins: d});
      expReq   = 1'b0;
      expValid = 1'b1;
      for (int unsigned k = 0; k < stall; k++) begin
         @(negedge CLK);
         drive(stray ? 1'($urandom) : 1'b0, $urandom, 1'b0);
         junk();
      end
      @(negedge CLK);
      drive(1'($urandom), $urandom, 1'b1);
      PcSrc    = src;
      PCWre    = wre;
      imm_ext  = imm;
      jaddr    = ja;
      expValid = 1'b0;
      if (wre) begin
         mpc = refNext(mpc, src, imm, ja);
         expFetch.push_back(mpc);
         expReq = 1'b1;
      end else begin
         holdPc  = mpc;
         expHalt = 1'b1;
      end
   endtask

   // Monitor / scoreboard
   initial begin
      issueT cur;
      logic  prevValid;
      prevValid = 1'b0;
      cur = '{pc: 32'h0, ins: 32'h0};
      forever begin
         @(posedge CLK);
         #2;
         if (checkEn) begin
            chkBit("imem_req", imem_req, expReq);
            chkBit("ins_valid", ins_valid, expValid);
            chkBit("halted", halted, expHalt);
            chkBit("fetch_err", fetch_err, expErr);
            if (expRst) begin
               chk("reset_pc", pc, RESET_PC);
               chk("reset_ins", ins, 32'h0);
               chk("reset_op", 32'(op), 32'h0);
            end
            if (expHalt) chk("halt_pc", pc, holdPc);
            if (imem_req) begin
               chkBit("fetch_expected", expFetch.size() != 0, 1'b1);
               if (expFetch.size() != 0) begin
                  chk("imem_addr", imem_addr, expFetch[0]);
                  chk("fetch_pc_plus4", pc_plus4, expFetch[0] + 32'd4);
               end
            end
            if (ins_valid && !prevValid) begin
               chkBit("issue_expected", expIssue.size() != 0, 1'b1);
               if (expIssue.size() != 0) begin
                  cur = expIssue.pop_front();
                  chk("issue_pc", pc, cur.pc);
                  chk("issue_ins", ins, cur.ins);
                  chk("issue_op", 32'(op), cur.ins >> 26);
                  if (expFetch.size() != 0) void'(expFetch.pop_front());
               end
            end else if (ins_valid) begin
               chk("hold_ins", ins, cur.ins);
               chk("hold_pc", pc, cur.pc);
            end
            prevValid = ins_valid;
         end
      end
   end

   // Stimulus
   initial begin
      Reset = 1'b0; PCWre = 1'b0; PcSrc = 2'b00; imm_ext = '0; jaddr = '0;
      ins_ready = 1'b0; imem_valid = 1'b0; imem_rdata = '0;
      mpc = RESET_PC; holdPc = '0;
      expReq = 1'b0; expValid = 1'b0; expHalt = 1'b0; expErr = 1'b0;
      expRst = 1'b0; checkEn = 1'b0;

      // Back-to-back sequential fetches with a zero-latency memory.
      doReset();
      for (int i = 0; i < 4; i++) runInstr(0, 0, 0, 2'b00, 1'b1, $urandom, 26'($urandom));

      // Branches backwards and forwards from 0x10, then into 0x1000_0040 and a jump.
      runInstr(0, 0, 0, 2'b01, 1'b1, 32'hFFFF_FFFE, 26'h0);
      runInstr(1, 0, 0, 2'b00, 1'b1, 32'h0, 26'h0);
      runInstr(0, 0, 0, 2'b01, 1'b1, 32'h0000_0003, 26'h0);
      runInstr(2, 0, 0, 2'b01, 1'b1, 32'h0400_0007, 26'h0);
      runInstr(0, 0, 0, 2'b10, 1'b1, 32'h0, 26'h100);

      // Long decode stall with stray responses, reserved PcSrc, then halt.
      runInstr(0, 5, 1, 2'b11, 1'b1, $urandom, 26'($urandom));
      runInstr(1, 2, 1, 2'b01, 1'b0, 32'h10, 26'h0);
      idle(20, 1);

      // Restart after halt, then fetch timeout.
      doReset();
      runInstr(0, 0, 0, 2'b00, 1'b1, 32'h0, 26'h0);
      runInstr(MAX_WAIT + 3, 0, 0, 2'b00, 1'b1, 32'h0, 26'h0);
      idle(5, 1);

      // Reset in the middle of a latency-3 fetch away from RESET_PC.
      doReset();
      runInstr(3, 0, 0, 2'b00, 1'b1, 32'h0, 26'h0);
      runInstr(3, 0, 0, 2'b00, 1'b1, 32'h0, 26'h0);
      idle(2, 0);
      doReset();
      runInstr(3, 0, 0, 2'b00, 1'b1, 32'h0, 26'h0);
      runInstr(MAX_WAIT - 1, 0, 0, 2'b00, 1'b1, 32'h0, 26'h0);

      // Randomized traffic.
      for (int i = 0; i < 80; i++) begin
         int unsigned lat, stl;
         logic [31:0] imm;
         lat = $urandom_range(0, 4);
         stl = $urandom_range(0, 3);
         imm = 32'($urandom_range(0, 64)) - 32'd32;
         runInstr(lat, stl, 1'($urandom), 2'($urandom), 1'b1, imm, 26'($urandom));
      end
      runInstr(1, 1, 1, 2'($urandom), 1'b0, $urandom, 26'($urandom));
      idle(4, 1);

      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule
